noc_traffic_pe: RTL and testbench

- Parametrised NoC traffic endpoint for testbenches: synthetic packet source plus checking sink, attached to one router local port at (XCORD,YCORD).
- Source injects NUM_PKTS packets at a fractional rate using a selectable destination pattern, with a full valid/ready handshake.
- Sink counts arrivals, flags misrouted packets and accumulates end-to-end latency from an embedded timestamp.

---
 rtl/noc_traffic_pe.sv | 224 ++++++++++++++++++++++
 tb/tb_noc_traffic_pe.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_traffic_pe.sv
// noc_traffic_pe
//   Synthetic NoC traffic endpoint. A source injects NUM_PKTS packets at a
//   fractional rate (RATE_NUM/RATE_DEN tokens per cycle) toward a destination
//   chosen by PATTERN. A sink counts ejected flits, flags misrouted ones and
//   accumulates end-to-end latency from the timestamp embedded in the payload.
//
//   Flit layout, LSB first:
//     dest_x | dest_y | src_x | src_y | payload
//     payload[15:0]  = sequence number
//     payload[47:16] = cycle_cnt at formation
//     payload[DATA_WIDTH-1:48] = 0
//
// Ports
//   clk, rstn        clock, synchronous active-low reset
//   o_data/o_valid   injected flit, held stable until i_ready
//   i_ready          router accepts o_data this cycle
//   i_data/i_valid   ejected flit; the sink never back-pressures
//   done             all NUM_PKTS packets accepted
//   tx_count         packets accepted by the router
//   rx_count         packets received (wraps)
//   rx_err           sticky: a received flit was not addressed to this node
//   lat_sum/lat_max  summed / maximum received latency
//   drop_count       injection tokens lost while a packet was pending (saturates)
module noc_traffic_pe #(
  parameter int XCORD       = 0,
  parameter int YCORD       = 0,
  parameter int X           = 4,
  parameter int Y           = 4,
  parameter int DEST_X      = 2,
  parameter int DEST_Y      = 2,
  parameter int SRC_X       = 8,
  parameter int SRC_Y       = 8,
  parameter int DATA_WIDTH  = 240,
  parameter int TOTAL_WIDTH = DEST_X + DEST_Y + SRC_X + SRC_Y + DATA_WIDTH,
  parameter int NUM_PKTS    = 3,
  parameter int RATE_NUM    = 1,
  parameter int RATE_DEN    = 1,
  parameter int PATTERN     = 0,
  parameter int HOT_X       = 0,
  parameter int HOT_Y       = 0,
  parameter int HOT_THRESH  = 64,
  parameter int NO_SELF     = 1,
  parameter int SEED        = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  output logic [TOTAL_WIDTH-1:0] o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  input  logic [TOTAL_WIDTH-1:0] i_data,
  input  logic                   i_valid,
  output logic                   done,
  output logic [15:0]            tx_count,
  output logic [15:0]            rx_count,
  output logic                   rx_err,
  output logic [47:0]            lat_sum,
  output logic [31:0]            lat_max,
  output logic [15:0]            drop_count
);

  // payload offset within the flit
  localparam int PO = DEST_X + DEST_Y + SRC_X + SRC_Y;
  // accumulator holds values < 2*RATE_DEN; one spare bit keeps the sum exact
  localparam int AW = $clog2(2 * RATE_DEN) + 1;

  localparam logic [AW:0]        RNUM     = (AW + 1)'(RATE_NUM);
  localparam logic [AW:0]        RDEN     = (AW + 1)'(RATE_DEN);
  localparam logic [31:0]        SEED_EFF = (SEED == 0) ? 32'd1 : 32'(SEED);
  localparam logic [31:0]        POLY     = 32'h8020_0003; // x^32+x^22+x^2+x+1
  localparam logic [31:0]        XW       = 32'(X);
  localparam logic [31:0]        YW       = 32'(Y);
  localparam logic [31:0]        XC       = 32'(XCORD);
  localparam logic [31:0]        YC       = 32'(YCORD);
  localparam logic [31:0]        HT       = 32'(HOT_THRESH);
  localparam logic [15:0]        NUMP     = 16'(NUM_PKTS);
  localparam logic [DEST_X-1:0]  OWN_DX   = DEST_X'(XCORD);
  localparam logic [DEST_Y-1:0]  OWN_DY   = DEST_Y'(YCORD);
  localparam logic [SRC_X-1:0]   OWN_SX   = SRC_X'(XCORD);
  localparam logic [SRC_Y-1:0]   OWN_SY   = SRC_Y'(YCORD);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  state_t                   state, state_nxt;
  logic [31:0]              cycle_cnt;
  logic [AW:0]              acc, acc_sum;
  logic                     token;
  logic [31:0]              lfsr, lfsr_nxt;
  logic [31:0]              ux, uy;
  logic                     hot;
  logic [DEST_X-1:0]        dx;
  logic [DEST_Y-1:0]        dy;
  logic [TOTAL_WIDTH-1:0]   flit;
  logic                     form, accept, drop;
  logic [31:0]              lat;
  logic                     misroute;
  logic                     unused_ok;

  // ---------------------------------------------------------------- rate
  assign acc_sum = acc + RNUM;
  assign token   = (acc_sum >= RDEN);

  // ---------------------------------------------------------------- lfsr
  // right-shifting Galois form; only advances when a packet is formed
  assign lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ POLY) : (lfsr >> 1);

  // ---------------------------------------------------------------- dest
  always_comb begin
    ux  = {16'd0, lfsr[15:0]} % XW;
    uy  = {16'd0, lfsr[31:16]} % YW;
    hot = ({24'd0, lfsr[7:0]} < HT);
    if (NO_SELF != 0 && ux == XC && uy == YC)
      ux = (ux + 32'd1) % XW;
    dx = DEST_X'(ux);
    dy = DEST_Y'(uy);
    case (PATTERN)
      1: begin
        dx = DEST_X'(YC);
        dy = DEST_Y'(XC);
      end
      2: begin
        dx = DEST_X'(XW - 32'd1 - XC);
        dy = DEST_Y'(YW - 32'd1 - YC);
      end
      3: begin
        if (hot) begin
          dx = DEST_X'(HOT_X);
          dy = DEST_Y'(HOT_Y);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    flit                              = '0;
    flit[DEST_X-1:0]                  = dx;
    flit[DEST_X +: DEST_Y]            = dy;
    flit[DEST_X+DEST_Y +: SRC_X]      = OWN_SX;
    flit[DEST_X+DEST_Y+SRC_X +: SRC_Y] = OWN_SY;
    flit[PO +: 16]                    = tx_count;
    flit[PO+16 +: 32]                 = cycle_cnt;
  end

  // ---------------------------------------------------------------- source fsm
  assign done = (tx_count == NUMP);

  always_comb begin
    state_nxt = state;
    form      = 1'b0;
    accept    = 1'b0;
    drop      = 1'b0;
    case (state)
      S_IDLE: begin
        if (done) begin
          state_nxt = S_DONE;
        end else if (token) begin
          form      = 1'b1;
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        // a token is never queued, even one coinciding with the accept
        drop = token;
        if (i_ready) begin
          accept    = 1'b1;
          state_nxt = ((tx_count + 16'd1) == NUMP) ? S_DONE : S_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= S_IDLE;
      cycle_cnt  <= '0;
      acc        <= '0;
      lfsr       <= SEED_EFF;
      o_data     <= '0;
      o_valid    <= 1'b0;
      tx_count   <= '0;
      drop_count <= '0;
    end else begin
      state     <= state_nxt;
      cycle_cnt <= cycle_cnt + 32'd1;
      acc       <= token ? (acc_sum - RDEN) : acc_sum;
      if (form) begin
        o_data  <= flit;
        o_valid <= 1'b1;
        lfsr    <= lfsr_nxt;
      end
      if (accept) begin
        o_valid  <= 1'b0;
        tx_count <= tx_count + 16'd1;
      end
      if (drop && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end

  // ---------------------------------------------------------------- sink
  assign lat       = cycle_cnt - i_data[PO+16 +: 32];
  assign misroute  = (i_data[DEST_X-1:0] != OWN_DX) ||
                     (i_data[DEST_X +: DEST_Y] != OWN_DY);
  // src fields and upper payload are carried but not checked
  assign unused_ok = ^i_data;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_count <= '0;
      rx_err   <= 1'b0;
      lat_sum  <= '0;
      lat_max  <= '0;
    end else if (i_valid) begin
      rx_count <= rx_count + 16'd1;
      if (misroute)
        rx_err <= 1'b1;
      lat_sum <= lat_sum + {16'd0, lat};
      if (lat > lat_max)
        lat_max <= lat;
    end
  end

endmodule

// File: tb/tb_noc_traffic_pe.sv
// Directed bench for noc_traffic_pe. Four instances with different parameter
// sets share one clock; each has its own reset so the scenarios stay apart.
module tb_noc_traffic_pe;

  localparam int TW = 260;
  localparam int PO = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  function automatic logic [TW-1:0] mk(input logic [1:0] dx, input logic [1:0] dy,
                                       input logic [31:0] ts);
    logic [TW-1:0] f;
    f = '0;
    f[1:0] = dx;
    f[3:2] = dy;
    f[PO+16 +: 32] = ts;
    return f;
  endfunction

  logic [TW-1:0] zdata = '0;
  logic          zvld  = 1'b0;

  // ---- instance A: transpose from (1,2), rate 1/1, 3 packets
  logic rst_a, rdy_a, ov_a, done_a, rxe_a;
  logic [TW-1:0] od_a;
  logic [15:0] txc_a, rxc_a, dc_a;
  logic [47:0] ls_a;
  logic [31:0] lm_a;
  noc_traffic_pe #(.XCORD(1), .YCORD(2), .NUM_PKTS(3), .PATTERN(1)) u_a (
    .clk(clk), .rstn(rst_a), .o_data(od_a), .o_valid(ov_a), .i_ready(rdy_a),
    .i_data(zdata), .i_valid(zvld), .done(done_a), .tx_count(txc_a),
    .rx_count(rxc_a), .rx_err(rxe_a), .lat_sum(ls_a), .lat_max(lm_a),
    .drop_count(dc_a));

  // ---- instance B: bit-complement from (0,0), rate 1/4, 4 packets
  logic rst_b, rdy_b, ov_b, done_b, rxe_b;
  logic [TW-1:0] od_b;
  logic [15:0] txc_b, rxc_b, dc_b;
  logic [47:0] ls_b;
  logic [31:0] lm_b;
  noc_traffic_pe #(.NUM_PKTS(4), .RATE_NUM(1), .RATE_DEN(4), .PATTERN(2)) u_b (
    .clk(clk), .rstn(rst_b), .o_data(od_b), .o_valid(ov_b), .i_ready(rdy_b),
    .i_data(zdata), .i_valid(zvld), .done(done_b), .tx_count(txc_b),
    .rx_count(rxc_b), .rx_err(rxe_b), .lat_sum(ls_b), .lat_max(lm_b),
    .drop_count(dc_b));

  // ---- instance C: uniform from (0,0), 1000 packets; also the sink under test
  logic rst_c, rdy_c, ov_c, done_c, rxe_c, ivl_c;
  logic [TW-1:0] od_c, idata_c;
  logic [15:0] txc_c, rxc_c, dc_c;
  logic [47:0] ls_c;
  logic [31:0] lm_c;
  noc_traffic_pe #(.NUM_PKTS(1000), .PATTERN(0), .NO_SELF(1)) u_c (
    .clk(clk), .rstn(rst_c), .o_data(od_c), .o_valid(ov_c), .i_ready(rdy_c),
    .i_data(idata_c), .i_valid(ivl_c), .done(done_c), .tx_count(txc_c),
    .rx_count(rxc_c), .rx_err(rxe_c), .lat_sum(ls_c), .lat_max(lm_c),
    .drop_count(dc_c));

  // ---- instance D: zero packets
  logic rst_d, rdy_d, ov_d, done_d, rxe_d;
  logic [TW-1:0] od_d;
  logic [15:0] txc_d, rxc_d, dc_d;
  logic [47:0] ls_d;
  logic [31:0] lm_d;
  noc_traffic_pe #(.NUM_PKTS(0)) u_d (
    .clk(clk), .rstn(rst_d), .o_data(od_d), .o_valid(ov_d), .i_ready(rdy_d),
    .i_data(zdata), .i_valid(zvld), .done(done_d), .tx_count(txc_d),
    .rx_count(rxc_d), .rx_err(rxe_d), .lat_sum(ls_d), .lat_max(lm_d),
    .drop_count(dc_d));

  // bench's own free-running cycle count for instance C's reset domain
  logic [31:0] cyc_c;
  always @(posedge clk) begin
    if (!rst_c) cyc_c <= '0;
    else        cyc_c <= cyc_c + 32'd1;
  end

  typedef struct {
    logic        vld;
    logic [1:0]  dx;
    logic [1:0]  dy;
    logic [31:0] lat;
    logic [15:0] e_rxc;
    logic        e_err;
    logic [47:0] e_sum;
    logic [31:0] e_max;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TW-1:0] fl;
    logic stable, seen;
    int w, got, self_hits, missing, total;
    int ts_b[4];
    int hits[4][4];

    tbl[0] = '{1'b1, 2'd0, 2'd0, 32'd15,         16'd1, 1'b0, 48'd15,            32'd15};
    tbl[1] = '{1'b1, 2'd0, 2'd0, 32'd7,          16'd2, 1'b0, 48'd22,            32'd15};
    tbl[2] = '{1'b0, 2'd3, 2'd3, 32'd99,         16'd2, 1'b0, 48'd22,            32'd15};
    tbl[3] = '{1'b1, 2'd2, 2'd1, 32'd5,          16'd3, 1'b1, 48'd27,            32'd15};
    tbl[4] = '{1'b1, 2'd0, 2'd0, 32'd20,         16'd4, 1'b1, 48'd47,            32'd20};
    tbl[5] = '{1'b0, 2'd0, 2'd0, 32'd0,          16'd4, 1'b1, 48'd47,            32'd20};
    tbl[6] = '{1'b1, 2'd0, 2'd0, 32'hFFFF_FFF0,  16'd5, 1'b1, 48'h1_0000_001F,   32'hFFFF_FFF0};
    ts_b = '{3, 15, 19, 23};

    rst_a = 0; rst_b = 0; rst_c = 0; rst_d = 0;
    rdy_a = 0; rdy_b = 0; rdy_c = 0; rdy_d = 1;
    ivl_c = 0; idata_c = '0;
    repeat (3) @(negedge clk);

    // ---------------- reset state
    chk("rst_ovalid", ov_a, 0);
    chk("rst_odata", od_a, 0);
    chk("rst_tx", txc_a, 0);
    chk("rst_drop", dc_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_rxc", rxc_c, 0);
    chk("rst_rxerr", rxe_c, 0);
    chk("rst_latsum", ls_c, 0);
    chk("rst_latmax", lm_c, 0);

    // ---------------- NUM_PKTS = 0
    rst_d = 1;
    @(negedge clk);
    chk("d_done_first", done_d, 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ov_d) seen = 1;
    end
    chk("d_never_valid", seen, 0);
    chk("d_done_end", done_d, 1);

    // ---------------- transpose, rate 1/1
    rdy_a = 1; rst_a = 1;
    got = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ov_a) begin
        chk("a_dx", od_a[1:0], 2);
        chk("a_dy", od_a[3:2], 1);
        chk("a_sx", od_a[11:4], 1);
        chk("a_sy", od_a[19:12], 2);
        chk("a_seq", od_a[PO +: 16], got);
        chk("a_ts", od_a[PO+16 +: 32], 2 * got);
        chk("a_hi_zero", |od_a[TW-1:PO+48], 0);
        got++;
      end
    end
    chk("a_pkts", got, 3);
    chk("a_done", done_a, 1);
    chk("a_valid_after", ov_a, 0);
    chk("a_tx", txc_a, 3);
    chk("a_drop", dc_a, 3);

    // ---------------- rate 1/4 with back-pressure
    rst_b = 1;
    w = 0;
    while (!ov_b && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("b_first_valid_cycle", w, 4);
    fl = od_b;
    chk("b_seq0", fl[PO +: 16], 0);
    chk("b_ts0", fl[PO+16 +: 32], 3);
    chk("b_dest", fl[3:0], 4'hF);
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!ov_b || od_b !== fl) stable = 0;
    end
    chk("b_hold_stable", stable, 1);
    chk("b_tx_held", txc_b, 0);
    chk("b_drop_held", dc_b, 2);
    rdy_b = 1;
    @(negedge clk);
    chk("b_tx_release", txc_b, 1);
    chk("b_drop_release", dc_b, 2);
    chk("b_valid_release", ov_b, 0);
    got = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ov_b && got < 4) begin
        chk("b_seq", od_b[PO +: 16], got);
        chk("b_ts", od_b[PO+16 +: 32], ts_b[got]);
        got++;
      end
    end
    chk("b_pkts", got, 4);
    chk("b_done", done_b, 1);
    chk("b_drop_final", dc_b, 2);

    // ---------------- reset while a packet is pending
    rst_b = 0;
    @(negedge clk);
    rst_b = 1;
    w = 0;
    while (!ov_b && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    chk("b2_tx_one", txc_b, 1);
    rdy_b = 0;
    w = 0;
    while (!ov_b && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("b2_pending", ov_b, 1);
    rst_b = 0;
    @(negedge clk);
    chk("b2_rst_valid", ov_b, 0);
    chk("b2_rst_tx", txc_b, 0);
    chk("b2_rst_done", done_b, 0);
    rst_b = 1;

    // ---------------- sink: misrouted flit
    rst_c = 1; rdy_c = 1;
    @(negedge clk);
    idata_c = mk(2'd3, 2'd3, cyc_c - 32'd3);
    ivl_c = 1;
    @(negedge clk);
    ivl_c = 0;
    chk("s_err_rxc", rxc_c, 1);
    chk("s_err_set", rxe_c, 1);
    chk("s_err_lat", ls_c, 3);
    repeat (2) @(negedge clk);
    chk("s_err_sticky", rxe_c, 1);
    rst_c = 0;
    @(negedge clk);
    chk("s_rst_err", rxe_c, 0);
    chk("s_rst_rxc", rxc_c, 0);
    rst_c = 1;

    // ---------------- sink: table of arrivals
    for (int i = 0; i < 7; i++) begin
      idata_c = mk(tbl[i].dx, tbl[i].dy, cyc_c - tbl[i].lat);
      ivl_c = tbl[i].vld;
      @(negedge clk);
      chk($sformatf("s_rxc[%0d]", i), rxc_c, tbl[i].e_rxc);
      chk($sformatf("s_err[%0d]", i), rxe_c, tbl[i].e_err);
      chk($sformatf("s_sum[%0d]", i), ls_c, tbl[i].e_sum);
      chk($sformatf("s_max[%0d]", i), lm_c, tbl[i].e_max);
    end
    ivl_c = 0;

    // ---------------- uniform destinations
    rst_c = 0;
    @(negedge clk);
    rst_c = 1;
    for (int yy = 0; yy < 4; yy++)
      for (int xx = 0; xx < 4; xx++)
        hits[yy][xx] = 0;
    self_hits = 0; total = 0; w = 0;
    while (!done_c && w < 3000) begin
      @(negedge clk);
      if (ov_c) begin
        hits[od_c[3:2]][od_c[1:0]]++;
        if (od_c[3:0] == 4'd0) self_hits++;
        total++;
      end
      w++;
    end
    chk("u_done", done_c, 1);
    chk("u_tx", txc_c, 1000);
    chk("u_total", total, 1000);
    chk("u_self", self_hits, 0);
    missing = 0;
    for (int yy = 0; yy < 4; yy++)
      for (int xx = 0; xx < 4; xx++)
        if (!(xx == 0 && yy == 0) && hits[yy][xx] == 0) missing++;
    chk("u_missing", missing, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
